mem_1r1w_masked_banked: RTL

Parametrised successor to the fixed-size 1R1W masked memory wrappers: a single-clock, byte-masked 1-read/1-write memory of arbitrary depth and width, built from `NBANKS` row banks of `BANK_DEPTH` entries each. It adds four behaviours to the plain bank-select wrapper:

- a post-reset zero-initialisation sweep;
- defined handling of out-of-range addresses;
- read-data hold when no read is issued;
- optional same-address read-during-write forwarding.

It sits between Chisel-generated `SyncReadMem` instances and the per-bank storage.

---
 rtl/mem_1r1w_masked_banked.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_1r1w_masked_banked.sv
// Banked, lane-masked 1R1W memory that zero-fills itself after reset and then serves one read and one write per cycle.
// Build option: define MEM_RDW_BYPASS_EN for write-first forwarding on same-address read/write collisions (read-first otherwise).
module mem_1r1w_masked_banked #(
  parameter int DEPTH      = 48,
  parameter int WIDTH      = 64,
  parameter int MASK_GRAN  = 8,
  parameter int BANK_DEPTH = 32,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int MASK_W    = WIDTH / MASK_GRAN
) (
  input  logic              clock,
  input  logic              reset,
  output logic              init_done,
  input  logic [ADDR_W-1:0] R0_addr,
  input  logic              R0_en,
  output logic [WIDTH-1:0]  R0_data,
  input  logic [ADDR_W-1:0] W0_addr,
  input  logic              W0_en,
  input  logic [WIDTH-1:0]  W0_data,
  input  logic [MASK_W-1:0] W0_mask
);

  localparam int NBANKS = (DEPTH + BANK_DEPTH - 1) / BANK_DEPTH;
  localparam int ROW_W  = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
  localparam int BANK_W = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam logic [31:0]       DEPTH_U   = 32'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {INIT, READY} state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [ADDR_W-1:0] r_sweepCnt;

  always_ff @(posedge clock) begin
    if (reset) r_state <= INIT;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    if (r_state == INIT && r_sweepCnt == LAST_ADDR) w_stateNext = READY;
  end

  always_ff @(posedge clock) begin
    if (reset)                r_sweepCnt <= '0;
    else if (r_state == INIT) r_sweepCnt <= r_sweepCnt + 1'b1;
  end

  assign init_done = (r_state == READY);

  // The sweep owns the write port during INIT; user traffic only reaches the banks in READY.
  logic              w_wrEn;
  logic [ADDR_W-1:0] w_wrAddr;
  logic [WIDTH-1:0]  w_wrData;
  logic [MASK_W-1:0] w_wrMask;
  logic              w_wrInRange;
  logic              w_rdInRange;
  logic              w_rdEn;

  assign w_wrInRange = 32'(W0_addr) < DEPTH_U;
  assign w_rdInRange = 32'(R0_addr) < DEPTH_U;
  assign w_rdEn      = !reset && (r_state == READY) && R0_en;

  always_comb begin
    w_wrEn   = 1'b0;
    w_wrAddr = W0_addr;
    w_wrData = W0_data;
    w_wrMask = W0_mask;
    if (!reset) begin
      if (r_state == INIT) begin
        w_wrEn   = 1'b1;
        w_wrAddr = r_sweepCnt;
        w_wrData = '0;
        w_wrMask = '1;
      end else begin
        w_wrEn = W0_en && w_wrInRange;
      end
    end
  end

  logic [31:0]       w_wrAddrExt;
  logic [31:0]       w_rdAddrExt;
  logic [BANK_W-1:0] w_wrBank;
  logic [BANK_W-1:0] w_rdBank;
  logic [ROW_W-1:0]  w_wrRow;
  logic [ROW_W-1:0]  w_rdRow;

  assign w_wrAddrExt = 32'(w_wrAddr);
  assign w_rdAddrExt = 32'(R0_addr);
  assign w_wrBank    = BANK_W'(w_wrAddrExt >> ROW_W);
  assign w_rdBank    = BANK_W'(w_rdAddrExt >> ROW_W);
  assign w_wrRow     = w_wrAddrExt[ROW_W-1:0];
  assign w_rdRow     = w_rdAddrExt[ROW_W-1:0];

  logic [WIDTH-1:0] w_bankQ [NBANKS];

  // Each bank is enabled only when the decoded bank index selects it.
  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic [WIDTH-1:0] r_mem [BANK_DEPTH];
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clock) begin
      if (w_wrEn && w_wrBank == BANK_W'(b)) begin
        for (int l = 0; l < MASK_W; l++) begin
          if (w_wrMask[l]) r_mem[w_wrRow][l*MASK_GRAN +: MASK_GRAN] <= w_wrData[l*MASK_GRAN +: MASK_GRAN];
        end
      end
      if (w_rdEn && w_rdInRange && w_rdBank == BANK_W'(b)) r_q <= r_mem[w_rdRow];
    end

    assign w_bankQ[b] = r_q;
  end

  // r_rdZero covers reset, the sweep and out-of-range reads; all read-side state freezes when no read is issued.
  logic              r_rdZero;
  logic [BANK_W-1:0] r_rdBank;
  logic [WIDTH-1:0]  w_rdWord;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdZero <= 1'b1;
      r_rdBank <= '0;
    end else if (w_rdEn) begin
      r_rdZero <= !w_rdInRange;
      if (w_rdInRange) r_rdBank <= w_rdBank;
    end
  end

`ifdef MEM_RDW_BYPASS_EN
  logic             w_collide;
  logic             r_fwd;
  logic [WIDTH-1:0] r_fwdData;
  logic [MASK_W-1:0] r_fwdMask;
  logic [WIDTH-1:0] w_fwdBits;

  assign w_collide = w_rdEn && w_rdInRange && w_wrEn && (R0_addr == W0_addr);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fwd     <= 1'b0;
      r_fwdData <= '0;
      r_fwdMask <= '0;
    end else if (w_rdEn) begin
      r_fwd     <= w_collide;
      r_fwdData <= W0_data;
      r_fwdMask <= W0_mask;
    end
  end

  always_comb begin
    w_fwdBits = '0;
    for (int l = 0; l < MASK_W; l++) begin
      w_fwdBits[l*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{r_fwd && r_fwdMask[l]}};
    end
  end

  assign w_rdWord = (w_bankQ[r_rdBank] & ~w_fwdBits) | (r_fwdData & w_fwdBits);
`else
  assign w_rdWord = w_bankQ[r_rdBank];
`endif

  assign R0_data = r_rdZero ? '0 : w_rdWord;

endmodule
